// File: rtl/snoop_broadcast_ctrl_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// snoop_broadcast_ctrl_if
// Bundles every snoop-bus signal of snoop_broadcast_ctrl: the upstream AC/CR/CD
// channels toward the coherency logic and the per-port AC/CR/CD channels
// toward the snooped masters. Per-port buses are packed [NoPorts-1:0][W-1:0].
//   slave  : view used by the controller (inputs are *_i, outputs are *_o)
//   master : view used by the surrounding environment (mirror of slave)
// ---------------------------------------------------------------------------
interface snoop_broadcast_ctrl_if #(
   parameter int NoPorts   = 2,
   parameter int AddrWidth = 64,
   parameter int DataWidth = 64
);
   // upstream snoop request
   logic [AddrWidth-1:0]                ac_addr_i;
   logic [2:0]                          ac_prot_i;
   logic [3:0]                          ac_snoop_i;
   logic                                ac_valid_i;
   logic                                ac_ready_o;
   logic [NoPorts-1:0]                  snoop_mask_i;
   // upstream merged response
   logic [4:0]                          cr_resp_o;
   logic                                cr_valid_o;
   logic                                cr_ready_i;
   // upstream forwarded data
   logic [DataWidth-1:0]                cd_data_o;
   logic                                cd_last_o;
   logic                                cd_valid_o;
   logic                                cd_ready_i;
   // downstream AC
   logic [NoPorts-1:0][AddrWidth-1:0]   ac_addr_o;
   logic [NoPorts-1:0][2:0]             ac_prot_o;
   logic [NoPorts-1:0][3:0]             ac_snoop_o;
   logic [NoPorts-1:0]                  ac_valid_o;
   logic [NoPorts-1:0]                  ac_ready_i;
   // downstream CR
   logic [NoPorts-1:0][4:0]             cr_resp_i;
   logic [NoPorts-1:0]                  cr_valid_i;
   logic [NoPorts-1:0]                  cr_ready_o;
   // downstream CD
   logic [NoPorts-1:0][DataWidth-1:0]   cd_data_i;
   logic [NoPorts-1:0]                  cd_last_i;
   logic [NoPorts-1:0]                  cd_valid_i;
   logic [NoPorts-1:0]                  cd_ready_o;

   modport slave (
      input  ac_addr_i, ac_prot_i, ac_snoop_i, ac_valid_i, snoop_mask_i,
      output ac_ready_o,
      output cr_resp_o, cr_valid_o,
      input  cr_ready_i,
      output cd_data_o, cd_last_o, cd_valid_o,
      input  cd_ready_i,
      output ac_addr_o, ac_prot_o, ac_snoop_o, ac_valid_o,
      input  ac_ready_i,
      input  cr_resp_i, cr_valid_i,
      output cr_ready_o,
      input  cd_data_i, cd_last_i, cd_valid_i,
      output cd_ready_o
   );

   modport master (
      output ac_addr_i, ac_prot_i, ac_snoop_i, ac_valid_i, snoop_mask_i,
      input  ac_ready_o,
      input  cr_resp_o, cr_valid_o,
      output cr_ready_i,
      input  cd_data_o, cd_last_o, cd_valid_o,
      output cd_ready_i,
      input  ac_addr_o, ac_prot_o, ac_snoop_o, ac_valid_o,
      output ac_ready_i,
      output cr_resp_i, cr_valid_i,
      input  cr_ready_o,
      output cd_data_i, cd_last_i, cd_valid_i,
      input  cd_ready_o
   );
endinterface

// File: rtl/snoop_broadcast_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// snoop_broadcast_ctrl
// Takes one snoop request from upstream, broadcasts it to the masked subset of
// NoPorts snooped masters, ORs their CR responses into one merged response,
// then forwards the CD burst of the lowest-index port that returned
// DataTransfer=1 while draining the bursts of every other such port.
// Ports:
//   clk_i  : clock
//   rst_ni : synchronous active-low reset
//   bus    : snoop_broadcast_ctrl_if.slave (upstream AC/CR/CD, per-port AC/CR/CD)
// ---------------------------------------------------------------------------
module snoop_broadcast_ctrl #(
   parameter int NoPorts   = 2,
   parameter int AddrWidth = 64,
   parameter int DataWidth = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   snoop_broadcast_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, BCAST, RESP, DATA} state_t;

   state_t                 r_state;
   state_t                 w_state_next;

   logic [AddrWidth-1:0]   r_addr;
   logic [2:0]             r_prot;
   logic [3:0]             r_snoop;
   logic [NoPorts-1:0]     r_mask;
   logic [NoPorts-1:0]     r_ac_done;
   logic [NoPorts-1:0]     r_cr_done;
   logic [NoPorts-1:0]     r_dt;        // ports that answered DataTransfer=1
   logic [NoPorts-1:0]     r_cd_done;   // tracked ports whose last beat was taken
   logic [4:0]             r_acc;

   logic                   w_ac_ready;
   logic                   w_cr_valid;
   logic                   w_ac_hs_up;
   logic                   w_bcast;
   logic                   w_data;
   logic [NoPorts-1:0]     w_ac_valid;
   logic [NoPorts-1:0]     w_cr_ready;
   logic [NoPorts-1:0]     w_cd_ready;
   logic [NoPorts-1:0]     w_ac_hs;
   logic [NoPorts-1:0]     w_cr_hs;
   logic [NoPorts-1:0]     w_cd_fin;
   logic [NoPorts-1:0]     w_resp_dt;
   logic [NoPorts-1:0]     w_sel_oh;
   logic [NoPorts-1:0]     w_drain;
   logic [NoPorts-1:0]     w_sel_live;
   logic [4:0]             w_resp_or;
   logic [DataWidth-1:0]   w_cd_data;
   logic                   w_cd_last;

   // Valid/ready outputs are qualified by rst_ni so they read 0 for the whole
   // time reset is held, not just from the edge after it is sampled.
   assign w_bcast    = rst_ni && (r_state == BCAST);
   assign w_data     = rst_ni && (r_state == DATA);
   assign w_ac_hs_up = w_ac_ready & bus.ac_valid_i;

   // Lowest set bit of r_dt is the forwarded port; the rest are drained.
   assign w_sel_oh   = r_dt & (~r_dt + NoPorts'(1));
   assign w_drain    = r_dt & ~w_sel_oh;
   assign w_sel_live = w_sel_oh & ~r_cd_done & {NoPorts{w_data}};

   genvar gi;
   generate
      for (gi = 0; gi < NoPorts; gi++) begin : g_port
         assign w_ac_valid[gi] = w_bcast & r_mask[gi] & ~r_ac_done[gi];
         assign w_cr_ready[gi] = w_bcast & r_ac_done[gi] & ~r_cr_done[gi];
         assign w_cd_ready[gi] = w_data & ~r_cd_done[gi] &
                                 (w_sel_oh[gi] ? bus.cd_ready_i : w_drain[gi]);

         assign w_ac_hs[gi]   = w_ac_valid[gi] & bus.ac_ready_i[gi];
         assign w_cr_hs[gi]   = w_cr_ready[gi] & bus.cr_valid_i[gi];
         assign w_cd_fin[gi]  = w_cd_ready[gi] & bus.cd_valid_i[gi] & bus.cd_last_i[gi];
         assign w_resp_dt[gi] = bus.cr_resp_i[gi][0];

         assign bus.ac_addr_o[gi]  = r_addr;
         assign bus.ac_prot_o[gi]  = r_prot;
         assign bus.ac_snoop_o[gi] = r_snoop;
      end
   endgenerate

   assign bus.ac_valid_o = w_ac_valid;
   assign bus.cr_ready_o = w_cr_ready;
   assign bus.cd_ready_o = w_cd_ready;

   // Merge every CR accepted this cycle; several ports may respond together.
   always_comb begin
      w_resp_or = 5'b0;
      for (int i = 0; i < NoPorts; i++) begin
         if (w_cr_hs[i]) begin
            w_resp_or = w_resp_or | bus.cr_resp_i[i];
         end
      end
   end

   // Combinational CD pass-through from the selected port.
   always_comb begin
      w_cd_data = '0;
      w_cd_last = 1'b0;
      for (int i = 0; i < NoPorts; i++) begin
         if (w_sel_live[i]) begin
            w_cd_data = w_cd_data | bus.cd_data_i[i];
            w_cd_last = w_cd_last | bus.cd_last_i[i];
         end
      end
   end

   assign bus.cd_data_o  = w_cd_data;
   assign bus.cd_last_o  = w_cd_last;
   assign bus.cd_valid_o = |(w_sel_live & bus.cd_valid_i);
   assign bus.ac_ready_o = w_ac_ready;
   assign bus.cr_valid_o = w_cr_valid;
   assign bus.cr_resp_o  = r_acc;

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state and handshake outputs
   always_comb begin
      w_state_next = r_state;
      w_ac_ready   = 1'b0;
      w_cr_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            w_ac_ready = rst_ni;
            if (bus.ac_valid_i) begin
               w_state_next = (|bus.snoop_mask_i) ? BCAST : RESP;
            end
         end
         BCAST: begin
            // Include this cycle's handshakes so CR valid follows the last one by a cycle.
            if ((r_cr_done | w_cr_hs) == r_mask) begin
               w_state_next = RESP;
            end
         end
         RESP: begin
            w_cr_valid = rst_ni;
            if (bus.cr_ready_i) begin
               w_state_next = r_acc[0] ? DATA : IDLE;
            end
         end
         DATA: begin
            if ((r_dt & ~(r_cd_done | w_cd_fin)) == '0) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Transaction tracking state
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_addr    <= '0;
         r_prot    <= '0;
         r_snoop   <= '0;
         r_mask    <= '0;
         r_ac_done <= '0;
         r_cr_done <= '0;
         r_dt      <= '0;
         r_cd_done <= '0;
         r_acc     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_ac_hs_up) begin
                  r_addr    <= bus.ac_addr_i;
                  r_prot    <= bus.ac_prot_i;
                  r_snoop   <= bus.ac_snoop_i;
                  r_mask    <= bus.snoop_mask_i;
                  r_ac_done <= '0;
                  r_cr_done <= '0;
                  r_dt      <= '0;
                  r_cd_done <= '0;
                  r_acc     <= '0;
               end
            end
            BCAST: begin
               r_ac_done <= r_ac_done | w_ac_hs;
               r_cr_done <= r_cr_done | w_cr_hs;
               r_dt      <= r_dt | (w_cr_hs & w_resp_dt);
               r_acc     <= r_acc | w_resp_or;
            end
            DATA: begin
               r_cd_done <= r_cd_done | w_cd_fin;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_snoop_broadcast_ctrl.sv
`timescale 1ns/1ps
module tb_snoop_broadcast_ctrl;
   localparam int NP = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   snoop_broadcast_ctrl_if #(.NoPorts(NP), .AddrWidth(AW), .DataWidth(DW)) bus ();

   snoop_broadcast_ctrl #(.NoPorts(NP), .AddrWidth(AW), .DataWidth(DW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.ac_addr_i = '0; bus.ac_prot_i = '0; bus.ac_snoop_i = '0;
      bus.ac_valid_i = 1'b0; bus.snoop_mask_i = '0;
      bus.cr_ready_i = 1'b0; bus.cd_ready_i = 1'b0;
      bus.ac_ready_i = '0; bus.cr_resp_i = '0; bus.cr_valid_i = '0;
      bus.cd_data_i = '0; bus.cd_last_i = '0; bus.cd_valid_i = '0;
   endtask

   // Present one upstream snoop; the handshake happens on the next edge.
   task automatic send_ac(input logic [AW-1:0] a, input logic [3:0] sn, input logic [NP-1:0] m);
      chk("ac_ready_before_send", 128'(bus.ac_ready_o), 128'(1));
      bus.ac_addr_i = a; bus.ac_prot_i = 3'b010; bus.ac_snoop_i = sn;
      bus.snoop_mask_i = m; bus.ac_valid_i = 1'b1;
      step();
      bus.ac_valid_i = 1'b0;
      bus.ac_addr_i = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ac_ready"}, 128'(bus.ac_ready_o), 128'(0));
      chk({tag, "_cr_valid"}, 128'(bus.cr_valid_o), 128'(0));
      chk({tag, "_cd_valid"}, 128'(bus.cd_valid_o), 128'(0));
      chk({tag, "_ac_valid"}, 128'(bus.ac_valid_o), 128'(0));
      chk({tag, "_cr_ready"}, 128'(bus.cr_ready_o), 128'(0));
      chk({tag, "_cd_ready"}, 128'(bus.cd_ready_o), 128'(0));
      chk({tag, "_cr_resp"},  128'(bus.cr_resp_o),  128'(0));
      chk({tag, "_cd_data"},  128'(bus.cd_data_o),  128'(0));
      chk({tag, "_cd_last"},  128'(bus.cd_last_o),  128'(0));
      chk({tag, "_ac_addr"},  128'(bus.ac_addr_o),  128'(0));
      chk({tag, "_ac_snoop"}, 128'(bus.ac_snoop_o), 128'(0));
   endtask

   initial begin
      int b0;
      int b1;
      logic rdy;

      // ---- reset with every valid/ready input asserted ----
      clear_inputs();
      bus.ac_valid_i = 1'b1; bus.snoop_mask_i = 2'b11; bus.ac_addr_i = 32'hDEAD_BEEF;
      bus.ac_ready_i = 2'b11; bus.cr_valid_i = 2'b11; bus.cr_resp_i[0] = 5'b11111;
      bus.cd_valid_i = 2'b11; bus.cd_ready_i = 1'b1; bus.cr_ready_i = 1'b1;
      bus.cd_data_i[0] = 32'h1234_5678; bus.cd_last_i = 2'b11;
      repeat (3) step();
      chk_all_zero("reset");
      clear_inputs();
      rst_n = 1'b1;
      #1;
      chk("post_reset_ac_ready", 128'(bus.ac_ready_o), 128'(1));
      $display("txn reset: outputs held at 0, ac_ready after release");

      // ---- mask 11, no data: responses 01000 and 00000 at different cycles ----
      send_ac(32'hA000_0040, 4'h1, 2'b11);
      chk("t1_ac_valid", 128'(bus.ac_valid_o), 128'(2'b11));
      chk("t1_ac_ready_low", 128'(bus.ac_ready_o), 128'(0));
      chk("t1_ac_addr", 128'(bus.ac_addr_o), 128'({32'hA000_0040, 32'hA000_0040}));
      chk("t1_ac_snoop", 128'(bus.ac_snoop_o), 128'({4'h1, 4'h1}));
      chk("t1_ac_prot", 128'(bus.ac_prot_o), 128'({3'b010, 3'b010}));
      bus.ac_ready_i = 2'b01;
      step();
      chk("t1_ac_valid_p1_only", 128'(bus.ac_valid_o), 128'(2'b10));
      chk("t1_cr_ready_p0", 128'(bus.cr_ready_o), 128'(2'b01));
      // Port 0 CR and port 1 AC complete in the same cycle.
      bus.ac_ready_i = 2'b10; bus.cr_valid_i = 2'b01; bus.cr_resp_i[0] = 5'b01000;
      step();
      bus.ac_ready_i = 2'b00; bus.cr_valid_i = 2'b00; bus.cr_resp_i[0] = 5'b0;
      chk("t1_ac_valid_none", 128'(bus.ac_valid_o), 128'(0));
      chk("t1_cr_ready_p1", 128'(bus.cr_ready_o), 128'(2'b10));
      chk("t1_cr_valid_wait", 128'(bus.cr_valid_o), 128'(0));
      step();
      chk("t1_cd_ready_bcast", 128'(bus.cd_ready_o), 128'(0));
      bus.cr_valid_i = 2'b10; bus.cr_resp_i[1] = 5'b00000;
      step();
      bus.cr_valid_i = 2'b00;
      chk("t1_cr_valid", 128'(bus.cr_valid_o), 128'(1));
      chk("t1_cr_resp", 128'(bus.cr_resp_o), 128'(5'b01000));
      step();
      chk("t1_cr_valid_held", 128'(bus.cr_valid_o), 128'(1));
      chk("t1_cr_resp_held", 128'(bus.cr_resp_o), 128'(5'b01000));
      chk("t1_cd_ready_resp", 128'(bus.cd_ready_o), 128'(0));
      bus.cr_ready_i = 1'b1;
      step();
      bus.cr_ready_i = 1'b0;
      chk("t1_idle_ac_ready", 128'(bus.ac_ready_o), 128'(1));
      chk("t1_idle_cr_valid", 128'(bus.cr_valid_o), 128'(0));
      chk("t1_idle_cd_ready", 128'(bus.cd_ready_o), 128'(0));
      $display("txn mask=11 snoop=1: merged resp 01000, no data");

      // ---- both ports 00101 with 4-beat bursts ----
      bus.ac_ready_i = 2'b11;
      send_ac(32'hB000_0080, 4'h7, 2'b11);
      step();
      bus.ac_ready_i = 2'b00;
      chk("t2_cr_ready_both", 128'(bus.cr_ready_o), 128'(2'b11));
      bus.cr_valid_i = 2'b11; bus.cr_resp_i[0] = 5'b00101; bus.cr_resp_i[1] = 5'b00101;
      // Data offered early must wait for DATA.
      bus.cd_valid_i = 2'b11; bus.cd_data_i[0] = 32'h100; bus.cd_data_i[1] = 32'h200;
      #1;
      chk("t2_cd_ready_early", 128'(bus.cd_ready_o), 128'(0));
      chk("t2_cd_valid_early", 128'(bus.cd_valid_o), 128'(0));
      step();
      bus.cr_valid_i = 2'b00;
      chk("t2_cr_resp", 128'(bus.cr_resp_o), 128'(5'b00101));
      chk("t2_cd_ready_resp", 128'(bus.cd_ready_o), 128'(0));
      bus.cr_ready_i = 1'b1;
      step();
      bus.cr_ready_i = 1'b0;
      b0 = 0;
      b1 = 0;
      for (int k = 0; k < 40 && (b0 < 4 || b1 < 4); k++) begin
         rdy = ((k % 3) != 1);
         bus.cd_ready_i = rdy;
         bus.cd_valid_i = {(b1 < 4), (b0 < 4)};
         bus.cd_data_i[0] = DW'(32'h100 + b0);
         bus.cd_data_i[1] = DW'(32'h200 + b1);
         bus.cd_last_i = {(b1 == 3), (b0 == 3)};
         #1;
         chk("t2_cd_valid", 128'(bus.cd_valid_o), 128'(b0 < 4));
         if (b0 < 4) begin
            chk("t2_cd_data", 128'(bus.cd_data_o), 128'(32'h100 + b0));
            chk("t2_cd_last", 128'(bus.cd_last_o), 128'(b0 == 3));
         end
         chk("t2_cd_ready", 128'(bus.cd_ready_o), 128'({(b1 < 4), (b0 < 4) && rdy}));
         @(posedge clk);
         if (rdy && b0 < 4) b0++;
         if (b1 < 4) b1++;
         #1;
      end
      bus.cd_valid_i = 2'b00; bus.cd_last_i = 2'b00; bus.cd_ready_i = 1'b0;
      #1;
      chk("t2_done_ac_ready", 128'(bus.ac_ready_o), 128'(1));
      chk("t2_done_cd_ready", 128'(bus.cd_ready_o), 128'(0));
      $display("txn both 00101: 4 beats forwarded from port 0, port 1 drained");

      // ---- mask 10 with AC backpressure on port 1 ----
      send_ac(32'hC000_00C0, 4'h9, 2'b10);
      for (int k = 0; k < 5; k++) begin
         chk("t3_ac_valid", 128'(bus.ac_valid_o), 128'(2'b10));
         chk("t3_ac_addr_stable", 128'(bus.ac_addr_o[1]), 128'(32'hC000_00C0));
         step();
      end
      bus.ac_ready_i = 2'b10;
      step();
      bus.ac_ready_i = 2'b00;
      chk("t3_cr_ready", 128'(bus.cr_ready_o), 128'(2'b10));
      bus.cr_valid_i = 2'b10; bus.cr_resp_i[1] = 5'b00010;
      step();
      bus.cr_valid_i = 2'b00;
      chk("t3_cr_valid", 128'(bus.cr_valid_o), 128'(1));
      chk("t3_cr_resp", 128'(bus.cr_resp_o), 128'(5'b00010));
      bus.cr_ready_i = 1'b1;
      step();
      bus.cr_ready_i = 1'b0;
      chk("t3_idle_ac_ready", 128'(bus.ac_ready_o), 128'(1));
      $display("txn mask=10: port 1 stalled 5 cycles, resp 00010");

      // ---- zero mask ----
      send_ac(32'hD000_0100, 4'h2, 2'b00);
      chk("t4_cr_valid", 128'(bus.cr_valid_o), 128'(1));
      chk("t4_cr_resp", 128'(bus.cr_resp_o), 128'(0));
      chk("t4_ac_valid", 128'(bus.ac_valid_o), 128'(0));
      bus.cr_ready_i = 1'b1;
      step();
      bus.cr_ready_i = 1'b0;
      chk("t4_idle_ac_ready", 128'(bus.ac_ready_o), 128'(1));
      $display("txn mask=00: immediate resp 0");

      // ---- reset in BCAST with port 1 pending, then a normal snoop ----
      bus.ac_ready_i = 2'b01;
      send_ac(32'hE000_0140, 4'h3, 2'b11);
      step();
      bus.ac_ready_i = 2'b00;
      chk("t5_pending_p1", 128'(bus.ac_valid_o), 128'(2'b10));
      rst_n = 1'b0;
      step();
      chk_all_zero("t5_reset");
      rst_n = 1'b1;
      #1;
      chk("t5_release_ac_ready", 128'(bus.ac_ready_o), 128'(1));
      bus.ac_ready_i = 2'b01;
      send_ac(32'hF000_0180, 4'h5, 2'b01);
      step();
      bus.ac_ready_i = 2'b00;
      bus.cr_valid_i = 2'b01; bus.cr_resp_i[0] = 5'b00001;
      step();
      bus.cr_valid_i = 2'b00;
      chk("t5_cr_resp", 128'(bus.cr_resp_o), 128'(5'b00001));
      bus.cr_ready_i = 1'b1;
      bus.cd_valid_i = 2'b01; bus.cd_data_i[0] = 32'h0000_0ABC; bus.cd_last_i = 2'b01;
      bus.cd_ready_i = 1'b1;
      step();
      bus.cr_ready_i = 1'b0;
      chk("t5_cd_valid", 128'(bus.cd_valid_o), 128'(1));
      chk("t5_cd_data", 128'(bus.cd_data_o), 128'(32'h0000_0ABC));
      chk("t5_cd_last", 128'(bus.cd_last_o), 128'(1));
      chk("t5_cd_ready", 128'(bus.cd_ready_o), 128'(2'b01));
      step();
      bus.cd_valid_i = 2'b00; bus.cd_last_i = 2'b00; bus.cd_ready_i = 1'b0;
      chk("t5_idle_ac_ready", 128'(bus.ac_ready_o), 128'(1));
      $display("txn mid-bcast reset then single-beat snoop");

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, %0d/%0d done", n_pass, n_tot);
      $fatal(1, "timeout");
   end
endmodule
